// File: rtl/tlb_refill_pkg.sv
// Shared definitions for the two-level page-table refill walker:
// state encoding, fault/miss codes and the table-entry address helper.
package tlb_refill_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StL1Req,
        StL1Wait,
        StL2Req,
        StL2Wait,
        StFill,
        StFault,
        StDrain
    } state_e;

    localparam logic [7:0] ExcPageInvalid = 8'h84;
    localparam logic [7:0] ExcProtection  = 8'h85;
    // Raised by the TLB itself on lookup misses; the walker never emits them.
    localparam logic [7:0] ExcMissLoad    = 8'h82;
    localparam logic [7:0] ExcMissStore   = 8'h83;

    function automatic logic [31:0] pt_addr(input logic [19:0] base, input logic [9:0] idx);
        return {base, idx, 2'b00};
    endfunction

endpackage

// File: rtl/tlb_refill.sv
// Hardware page-table walker: on a TLB miss it fetches the PDE and PTE with
// one outstanding memory request and either writes the TLB or reports a fault.
module tlb_refill
    import tlb_refill_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        clear,
    input  logic        miss_valid,
    output logic        miss_ready,
    input  logic [31:0] miss_key,
    input  logic        miss_kmode,
    input  logic [31:0] ptbr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        tlb_we,
    output logic [31:0] tlb_key,
    output logic [31:0] tlb_data,
    output logic        busy,
    output logic [7:0]  exc_out,
    output logic        done
);

    state_e      state_q;
    logic [31:0] key_q;
    logic        kmode_q;
    logic [19:0] pde_base_q;
    logic [5:0]  frame_q;
    logic [7:0]  code_q;
    logic        fill_ok;
    logic        fault_ok;
    logic        unused_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            key_q      <= '0;
            kmode_q    <= 1'b0;
            pde_base_q <= '0;
            frame_q    <= '0;
            code_q     <= '0;
        end else if (clk_en) begin
            unique case (state_q)
                StIdle: begin
                    if (miss_valid && !clear) begin
                        key_q   <= miss_key;
                        kmode_q <= miss_kmode;
                        state_q <= StL1Req;
                    end
                end
                StL1Req: begin
                    if (clear)              state_q <= StIdle;
                    else if (mem_req_ready) state_q <= StL1Wait;
                end
                StL1Wait: begin
                    // A response arriving with clear is the one DRAIN would have eaten.
                    if (clear) begin
                        state_q <= mem_resp_valid ? StIdle : StDrain;
                    end else if (mem_resp_valid) begin
                        pde_base_q <= mem_resp_data[31:12];
                        if (!mem_resp_data[0]) begin
                            code_q  <= ExcPageInvalid;
                            state_q <= StFault;
                        end else begin
                            state_q <= StL2Req;
                        end
                    end
                end
                StL2Req: begin
                    if (clear)              state_q <= StIdle;
                    else if (mem_req_ready) state_q <= StL2Wait;
                end
                StL2Wait: begin
                    if (clear) begin
                        state_q <= mem_resp_valid ? StIdle : StDrain;
                    end else if (mem_resp_valid) begin
                        frame_q <= mem_resp_data[17:12];
                        if (!mem_resp_data[0]) begin
                            code_q  <= ExcPageInvalid;
                            state_q <= StFault;
                        end else if (!kmode_q && !mem_resp_data[1]) begin
                            code_q  <= ExcProtection;
                            state_q <= StFault;
                        end else begin
                            state_q <= StFill;
                        end
                    end
                end
                StFill, StFault: state_q <= StIdle;
                StDrain: begin
                    if (mem_resp_valid) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // A clear in the final cycle cancels the fill/fault report.
    assign fill_ok  = (state_q == StFill) && !clear;
    assign fault_ok = (state_q == StFault) && !clear;

    assign miss_ready    = (state_q == StIdle) && !clear && !rst;
    assign mem_req_valid = (state_q == StL1Req) || (state_q == StL2Req);
    assign busy          = (state_q != StIdle);
    assign tlb_we        = fill_ok;
    assign tlb_key       = fill_ok ? key_q : '0;
    assign tlb_data      = fill_ok ? {26'b0, frame_q} : '0;
    assign done          = fill_ok || fault_ok;
    assign exc_out       = fault_ok ? code_q : '0;

    always_comb begin
        mem_req_addr = '0;
        if (state_q == StL1Req)      mem_req_addr = pt_addr(ptbr[31:12], key_q[19:10]);
        else if (state_q == StL2Req) mem_req_addr = pt_addr(pde_base_q, key_q[9:0]);
    end

    assign unused_bits = ^{ptbr[11:0], mem_resp_data[11:2]};

endmodule

// File: tb/tb_tlb_refill.sv
// Directed bench for tlb_refill: a reference walk model plus memory responder,
// checked every cycle, with hand-computed literals for the key scenarios.
module tb_tlb_refill;

    logic        clk = 1'b0;
    logic        rst, clk_en, clear;
    logic        miss_valid, miss_ready, miss_kmode;
    logic [31:0] miss_key, ptbr;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        tlb_we;
    logic [31:0] tlb_key, tlb_data;
    logic        busy, done;
    logic [7:0]  exc_out;

    tlb_refill dut (
        .clk            (clk),
        .rst            (rst),
        .clk_en         (clk_en),
        .clear          (clear),
        .miss_valid     (miss_valid),
        .miss_ready     (miss_ready),
        .miss_key       (miss_key),
        .miss_kmode     (miss_kmode),
        .ptbr           (ptbr),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .tlb_we         (tlb_we),
        .tlb_key        (tlb_key),
        .tlb_data       (tlb_data),
        .busy           (busy),
        .exc_out        (exc_out),
        .done           (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        is_fill;
        logic [31:0] key;
        logic [31:0] data;
        logic [7:0]  code;
    } res_t;

    res_t        exp_res[$];
    logic [31:0] exp_addr[$];
    logic [31:0] mem [logic [31:0]];

    task automatic model_walk(input logic [31:0] key, input logic km,
                              input logic [31:0] pde, input logic [31:0] pte);
        logic [31:0] a1, a2;
        res_t r;
        a1 = (ptbr & 32'hFFFF_F000) + ({22'b0, key[19:10]} * 4);
        exp_addr.push_back(a1);
        mem[a1] = pde;
        r = '{is_fill: 1'b0, key: key, data: 32'h0, code: 8'h00};
        if (pde % 2 == 0) begin
            r.code = 8'h84;
        end else begin
            a2 = (pde & 32'hFFFF_F000) + ({22'b0, key[9:0]} * 4);
            exp_addr.push_back(a2);
            mem[a2] = pte;
            if (pte % 2 == 0)                 r.code = 8'h84;
            else if (!km && ((pte / 2) % 2 == 0)) r.code = 8'h85;
            else begin
                r.is_fill = 1'b1;
                r.data    = (pte / 4096) % 64;
            end
        end
        exp_res.push_back(r);
    endtask

    // ---------------- per-cycle compare + memory responder ----------------
    int          cyc = 0, acc_cyc = 0, fill_lat = -1, hs_cnt = 0, we_cnt = 0, done_cnt = 0;
    int          l2_delay = 0, bp_cnt = 0, resp_cd = -1;
    logic [31:0] seen_addr [4];
    logic [31:0] last_key, last_data, pend_addr, p_addr;
    logic [7:0]  last_exc;
    logic        p_valid, p_ready, p_resp, p_fire, p_clear;

    initial begin
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        p_valid = 0; p_ready = 0; p_resp = 0; p_fire = 0; p_clear = 0; p_addr = '0;
        pend_addr = '0; last_key = '0; last_data = '0; last_exc = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_ctl", {27'b0, miss_ready, mem_req_valid, tlb_we, busy, done}, 32'h0);
                chk("rst_vals", mem_req_addr | tlb_key | tlb_data | {24'b0, exc_out}, 32'h0);
                mem_resp_valid = 1'b0; resp_cd = -1;
                p_valid = 0; p_resp = 0; p_fire = 0;
                continue;
            end
            if (p_fire && p_valid && p_ready) begin
                if (exp_addr.size() != 0) void'(exp_addr.pop_front());
                if (hs_cnt < 4) seen_addr[hs_cnt] = p_addr;
                resp_cd   = (hs_cnt == 1) ? l2_delay : 0;
                hs_cnt++;
                pend_addr = p_addr;
            end
            if (p_fire && p_resp) mem_resp_valid = 1'b0;
            if (resp_cd == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
                resp_cd = -1;
            end else if (resp_cd > 0) begin
                resp_cd--;
            end

            if (mem_req_valid) begin
                chk("req_addr", mem_req_addr, (exp_addr.size() != 0) ? exp_addr[0] : 32'hFFFF_FFFF);
                if (p_valid && !(p_fire && p_ready)) chk("req_stable", mem_req_addr, p_addr);
            end else if (p_valid && !(p_fire && p_ready) && !p_clear) begin
                chk("req_held", {31'b0, mem_req_valid}, 32'h1);
            end
            if (tlb_we || done) begin
                res_t r;
                r = (exp_res.size() != 0) ? exp_res[0]
                                          : '{is_fill: 1'b0, key: 32'h0, data: 32'h0, code: 8'hFF};
                chk("fill_flag", {31'b0, tlb_we}, {31'b0, r.is_fill});
                chk("done", {31'b0, done}, 32'h1);
                chk("exc_out", {24'b0, exc_out}, r.is_fill ? 32'h0 : {24'b0, r.code});
                if (tlb_we) begin
                    chk("tlb_key", tlb_key, r.key);
                    chk("tlb_data", tlb_data, r.data);
                end
                if (clk_en) begin
                    if (exp_res.size() != 0) void'(exp_res.pop_front());
                    done_cnt++;
                    last_exc = exc_out;
                    if (tlb_we) begin
                        we_cnt++; last_key = tlb_key; last_data = tlb_data;
                        fill_lat = cyc - acc_cyc;
                    end
                end
            end
            if (miss_ready) chk("ready_not_busy", {31'b0, busy}, 32'h0);
            if (miss_valid && miss_ready && clk_en) acc_cyc = cyc;

            mem_req_ready = (bp_cnt == 0);
            if (mem_req_valid && clk_en && bp_cnt > 0) bp_cnt--;
            p_valid = mem_req_valid; p_ready = mem_req_ready; p_addr = mem_req_addr;
            p_resp  = mem_resp_valid; p_fire = clk_en; p_clear = clear;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_miss(input logic [31:0] key, input logic km);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        miss_key = key; miss_kmode = km; miss_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (miss_ready && clk_en) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", {31'b0, miss_ready}, 32'h1);
        @(posedge clk); #1;
        miss_valid = 1'b0;
    endtask

    task automatic wait_result();
        for (int i = 0; i < 60 && exp_res.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        chk("walk_timeout", exp_res.size(), 32'h0);
    endtask

    task automatic run_walk(input logic [31:0] key, input logic km,
                            input logic [31:0] pde, input logic [31:0] pte);
        hs_cnt = 0; fill_lat = -1;
        model_walk(key, km, pde, pte);
        start_miss(key, km);
        wait_result();
    endtask

    task automatic wait_hs(input int n);
        for (int i = 0; i < 40 && hs_cnt < n; i++) begin
            @(negedge clk); #1;
        end
        chk("hs_timeout", hs_cnt, n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    localparam logic [31:0] Key = 32'h0010_0403;
    int we0, done0;

    initial begin
        rst = 1'b1; clk_en = 1'b1; clear = 1'b0;
        miss_valid = 1'b0; miss_key = '0; miss_kmode = 1'b0;
        ptbr = 32'h0001_0ABC;  // low 12 bits must be ignored
        repeat (2) @(negedge clk);
        #1;
        chk("reset_miss_ready", {31'b0, miss_ready}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("idle_ready", {31'b0, miss_ready}, 32'h1);

        // clear together with a miss in IDLE: not accepted
        clear = 1'b1; miss_valid = 1'b1; miss_key = Key;
        #1 chk("clear_blocks_ready", {31'b0, miss_ready}, 32'h0);
        @(posedge clk); #1;
        clear = 1'b0; miss_valid = 1'b0;
        @(negedge clk); #1;
        chk("clear_no_accept", {31'b0, busy}, 32'h0);

        // hit path
        run_walk(Key, 1'b0, 32'h0002_0001, 32'h0002_F003);
        chk("hit_hs_count", hs_cnt, 32'd2);
        chk("hit_l1_addr", seen_addr[0], 32'h0001_0004);
        chk("hit_l2_addr", seen_addr[1], 32'h0002_000C);
        chk("hit_key", last_key, 32'h0010_0403);
        chk("hit_data", last_data, 32'h0000_002F);
        chk("hit_latency", fill_lat, 32'd5);

        // invalid PDE
        we0 = we_cnt;
        run_walk(Key, 1'b0, 32'h0002_0000, 32'h0002_F003);
        chk("pde_hs_count", hs_cnt, 32'd1);
        chk("pde_exc", {24'b0, last_exc}, 32'h84);
        chk("pde_no_we", we_cnt, we0);

        // protection, then same walk in kernel mode
        run_walk(Key, 1'b0, 32'h0002_0001, 32'h0002_F001);
        chk("prot_exc", {24'b0, last_exc}, 32'h85);
        run_walk(Key, 1'b1, 32'h0002_0001, 32'h0002_F001);
        chk("kmode_fill_data", last_data, 32'h0000_002F);
        chk("kmode_fill_exc", {24'b0, last_exc}, 32'h0);

        // invalid PTE
        run_walk(32'h0ABC_07FF, 1'b1, 32'h0003_5001, 32'h0001_2002);
        chk("pte_exc", {24'b0, last_exc}, 32'h84);

        // backpressure plus global stall
        bp_cnt = 3;
        fork
            run_walk(Key, 1'b0, 32'h0002_0001, 32'h0002_F003);
            begin
                repeat (3) begin @(posedge clk); #1; end
                clk_en = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
                clk_en = 1'b1;
            end
        join
        chk("bp_key", last_key, 32'h0010_0403);
        chk("bp_data", last_data, 32'h0000_002F);
        chk("bp_l1_addr", seen_addr[0], 32'h0001_0004);

        // abort in L2_WAIT with the response two cycles later
        we0 = we_cnt; done0 = done_cnt; hs_cnt = 0; l2_delay = 2;
        model_walk(Key, 1'b1, 32'h0002_0001, 32'h0002_F003);
        start_miss(Key, 1'b1);
        wait_hs(2);
        clear = 1'b1;
        exp_addr.delete(); exp_res.delete();
        @(posedge clk); #1;
        clear = 1'b0;
        for (int i = 0; i < 10 && !mem_resp_valid; i++) begin
            @(negedge clk); #1;
        end
        chk("drain_resp_seen", {31'b0, mem_resp_valid}, 32'h1);
        chk("drain_busy", {31'b0, busy}, 32'h1);
        @(negedge clk); #1;
        chk("abort_ready", {31'b0, miss_ready}, 32'h1);
        chk("abort_no_we", we_cnt, we0);
        chk("abort_no_done", done_cnt, done0);
        l2_delay = 0;

        // asynchronous reset in L1_WAIT
        hs_cnt = 0;
        model_walk(Key, 1'b0, 32'h0002_0001, 32'h0002_F003);
        start_miss(Key, 1'b0);
        wait_hs(1);
        chk("pre_rst_busy", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        exp_addr.delete(); exp_res.delete();
        #1;
        chk("async_rst_ctl", {27'b0, miss_ready, mem_req_valid, tlb_we, busy, done}, 32'h0);
        chk("async_rst_exc", {24'b0, exc_out}, 32'h0);
        @(negedge clk); #1;
        rst = 1'b0;
        run_walk(Key, 1'b0, 32'h0002_0001, 32'h0002_F003);
        chk("post_rst_data", last_data, 32'h0000_002F);
        chk("post_rst_latency", fill_lat, 32'd5);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
